// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline.
// Turns the load-use, taken-branch and data-memory-wait conditions into
// hold/flush/bubble controls, and keeps saturating performance counters
// plus a sticky memory-timeout fault.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_rgWrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_hold,
  output logic             Pause,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             hold_back,
  output logic             fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYC);
  localparam logic [7:0]       TIMEOUT_W  = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     cur_state;
  state_t     nxt_state;
  logic [2:0] left;
  logic [2:0] left_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       fault_q;
  logic       load_use;
  logic       freeze;
  logic       take_branch;

  // A load in EX whose destination the ID instruction reads; x0 never conflicts.
  always_comb begin
    load_use = ex_MemRead & ex_rgWrite & (ex_rd != '0) &
               ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                (id_uses_rs2 & (id_rs2 == ex_rd)));
    freeze   = dmem_req & ~dmem_ready;
  end

  // Next-state and Mealy control outputs: freeze beats branch beats load-use.
  always_comb begin
    nxt_state   = cur_state;
    left_nxt    = left;
    wait_nxt    = wait_cnt;
    take_branch = 1'b0;
    pc_hold     = 1'b0;
    Pause       = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    hold_back   = 1'b0;
    case (cur_state)
      FAULT: begin
        pc_hold   = 1'b1;
        Pause     = 1'b1;
        hold_back = 1'b1;
      end
      default: begin
        if (freeze) begin
          pc_hold   = 1'b1;
          Pause     = 1'b1;
          hold_back = 1'b1;
          wait_nxt  = 8'(wait_cnt + 8'd1);
          if (wait_nxt == TIMEOUT_W) begin
            nxt_state = FAULT;
          end
        end else begin
          wait_nxt = 8'd0;
          if (cur_state == FLUSH) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            left_nxt    = 3'(left - 3'd1);
            if (left == 3'd1) begin
              nxt_state = RUN;
            end
          end else if (ex_branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            take_branch = 1'b1;
            if (FLUSH_CYC > 0) begin
              nxt_state = FLUSH;
              left_nxt  = FLUSH_INIT;
            end
          end else if (load_use) begin
            pc_hold     = 1'b1;
            Pause       = 1'b1;
            bubble_idex = 1'b1;
          end
        end
      end
    endcase
    if (rst) begin
      pc_hold     = 1'b0;
      Pause       = 1'b0;
      flush_ifid  = 1'b0;
      bubble_idex = 1'b0;
      hold_back   = 1'b0;
      take_branch = 1'b0;
    end
  end

  // State register with squash countdown, memory-wait counter and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
      left      <= 3'd0;
      wait_cnt  <= 8'd0;
      fault_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      left      <= left_nxt;
      wait_cnt  <= wait_nxt;
      fault_q   <= (nxt_state == FAULT);
    end
  end

  // Saturating performance counters: stalled cycles and accepted branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (take_branch && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign fault = fault_q;
  assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model, on two differently parameterised instances.
module tb_hazard_ctrl;

  localparam int CNT_A = 4;
  localparam int FC_A  = 3;
  localparam int TO_A  = 4;
  localparam int CNT_B = 6;
  localparam int FC_B  = 0;
  localparam int TO_B  = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_uses_rs1 = 1'b0;
  logic       id_uses_rs2 = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_MemRead = 1'b0;
  logic       ex_rgWrite = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;

  logic pc_hold_a, pause_a, flush_a, bubble_a, hold_a, fault_a;
  logic pc_hold_b, pause_b, flush_b, bubble_b, hold_b, fault_b;
  logic [1:0] state_a, state_b;
  logic [CNT_A-1:0] stall_cnt_a, flush_cnt_a;
  logic [CNT_B-1:0] stall_cnt_b, flush_cnt_b;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_ctrl #(.REG_W(5), .CNT_W(CNT_A), .FLUSH_CYC(FC_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_rgWrite(ex_rgWrite),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold_a), .Pause(pause_a), .flush_ifid(flush_a), .bubble_idex(bubble_a),
    .hold_back(hold_a), .fault(fault_a), .state(state_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(CNT_B), .FLUSH_CYC(FC_B), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_MemRead(ex_MemRead), .ex_rgWrite(ex_rgWrite),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_hold(pc_hold_b), .Pause(pause_b), .flush_ifid(flush_b), .bubble_idex(bubble_b),
    .hold_back(hold_b), .fault(fault_b), .state(state_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  // Model: faulted flag, squash cycles still owed, wait streak, counters.
  typedef struct {
    int faulted;
    int owed;
    int waitc;
    int stalls;
    int branches;
  } model_t;

  model_t ma;
  model_t mb;

  // Expected {pc_hold, Pause, flush_ifid, bubble_idex, hold_back, fault}.
  function automatic logic [5:0] exp_ctrl(model_t m);
    bit fz;
    bit lu;
    fz = dmem_req && !dmem_ready;
    lu = ex_MemRead && ex_rgWrite && (ex_rd != 0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (rst)                               return 6'b000000;
    if (m.faulted != 0)                    return 6'b110011;
    if (fz)                                return 6'b110010;
    if (m.owed > 0 || ex_branch_taken)     return 6'b001100;
    if (lu)                                return 6'b110100;
    return 6'b000000;
  endfunction

  function automatic int exp_state(model_t m);
    if (m.faulted != 0) return 2;
    if (m.owed > 0)     return 1;
    return 0;
  endfunction

  function automatic model_t step(model_t m, int fc, int to, int cmax);
    logic [5:0] c;
    model_t n;
    n = m;
    c = exp_ctrl(m);
    if (c[5] && n.stalls < cmax) n.stalls++;
    if (n.faulted != 0) return n;
    if (dmem_req && !dmem_ready) begin
      n.waitc++;
      if (n.waitc == to) n.faulted = 1;
    end else begin
      n.waitc = 0;
      if (n.owed > 0) begin
        n.owed--;
      end else if (ex_branch_taken) begin
        if (n.branches < cmax) n.branches++;
        n.owed = fc;
      end
    end
    return n;
  endfunction

  // Advance both models on each clock edge; reset them asynchronously.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = '{0, 0, 0, 0, 0};
      mb = '{0, 0, 0, 0, 0};
    end else begin
      ma = step(ma, FC_A, TO_A, (1 << CNT_A) - 1);
      mb = step(mb, FC_B, TO_B, (1 << CNT_B) - 1);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Compare every output of both instances against the model mid-cycle.
  always @(negedge clk) begin
    checkOutput("a_ctrl", int'({pc_hold_a, pause_a, flush_a, bubble_a, hold_a, fault_a}),
                int'(exp_ctrl(ma)));
    checkOutput("a_state", int'(state_a), exp_state(ma));
    checkOutput("a_stall_cnt", int'(stall_cnt_a), ma.stalls);
    checkOutput("a_flush_cnt", int'(flush_cnt_a), ma.branches);
    checkOutput("b_ctrl", int'({pc_hold_b, pause_b, flush_b, bubble_b, hold_b, fault_b}),
                int'(exp_ctrl(mb)));
    checkOutput("b_state", int'(state_b), exp_state(mb));
    checkOutput("b_stall_cnt", int'(stall_cnt_b), mb.stalls);
    checkOutput("b_flush_cnt", int'(flush_cnt_b), mb.branches);
  end

  task automatic applyStimulus(input bit br, input bit mr, input bit rw, input int rd,
                               input bit u1, input int r1, input bit u2, input int r2,
                               input bit req, input bit rdy);
    @(posedge clk);
    #1;
    ex_branch_taken = br;
    ex_MemRead      = mr;
    ex_rgWrite      = rw;
    ex_rd           = 5'(rd);
    id_uses_rs1     = u1;
    id_rs1          = 5'(r1);
    id_uses_rs2     = u2;
    id_rs2          = 5'(r2);
    dmem_req        = req;
    dmem_ready      = rdy;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic loadUse();
    applyStimulus(0, 1, 1, 5, 0, 0, 1, 5, 0, 0);
  endtask

  task automatic freezeCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int n;

    // Reset forces controls low even with a freeze request present.
    freezeCycle();
    #1;
    checkOutput("rst_forces_pc_hold", int'(pc_hold_a), 0);
    checkOutput("rst_state", int'(state_a), 0);
    idle();
    rst = 1'b0;

    // Load-use: one-cycle stall with bubble.
    loadUse();
    #1;
    checkOutput("lu_ctrl", int'({pc_hold_a, pause_a, flush_a, bubble_a}), 4'b1101);
    idle();
    #1;
    checkOutput("lu_released", int'(pc_hold_a), 0);
    checkOutput("lu_stall_cnt", int'(stall_cnt_a), 1);
    checkOutput("lu_state", int'(state_a), 0);

    // Taken branch: 1 + FLUSH_CYC squash cycles on A, single cycle on B.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("br_detect_flush", int'({flush_a, bubble_a}), 2'b11);
    idle();
    #1;
    checkOutput("br_state_a", int'(state_a), 1);
    checkOutput("br_state_b", int'(state_b), 0);
    checkOutput("br_b_no_extra", int'(flush_b), 0);
    checkOutput("br_flush_cnt", int'(flush_cnt_a), 1);
    n = int'(flush_a);
    for (int i = 0; i < 5; i++) begin
      idle();
      #1;
      n += int'(flush_a);
    end
    checkOutput("br_extra_squash", n, 3);

    // Freeze precedence over a held branch and load-use match.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1, 5, 0, 0, 1, 5, 1, 0);
      #1;
      checkOutput("frz_prec", int'({hold_a, pc_hold_a, flush_a, bubble_a}), 4'b1100);
    end
    applyStimulus(1, 1, 1, 5, 0, 0, 1, 5, 1, 1);
    #1;
    checkOutput("frz_release_branch", int'({hold_a, flush_a, bubble_a}), 3'b011);
    idle();
    #1;
    checkOutput("frz_flush_cnt", int'(flush_cnt_a), 2);
    repeat (5) idle();

    // Freeze inside FLUSH: squash cycles paused, not lost.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n = int'(flush_a);
    for (int i = 0; i < 2; i++) begin
      freezeCycle();
      #1;
      checkOutput("flush_gap", int'(flush_a), 0);
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      #1;
      n += int'(flush_a);
    end
    checkOutput("flush_total", n, 4);

    // Timeout after TIMEOUT freeze cycles, sticky until reset.
    repeat (4) freezeCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checkOutput("to_state", int'(state_a), 2);
    checkOutput("to_fault", int'(fault_a), 1);
    checkOutput("to_pc_hold", int'(pc_hold_a), 1);
    idle();
    #1;
    checkOutput("to_sticky", int'(fault_a), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_state", int'(state_a), 0);
    checkOutput("arst_fault", int'(fault_a), 0);
    checkOutput("arst_stall_cnt", int'(stall_cnt_a), 0);
    idle();
    rst = 1'b0;

    // Saturation: 20 stalls on a 4-bit counter stop at 15.
    repeat (20) loadUse();
    idle();
    #1;
    checkOutput("sat_stall_a", int'(stall_cnt_a), 15);
    checkOutput("sat_stall_b", int'(stall_cnt_b), 20);
    applyStimulus(0, 1, 1, 0, 1, 0, 1, 0, 0, 0);
    #1;
    checkOutput("rd0_no_stall", int'({pc_hold_a, bubble_a}), 0);

    // Randomized traffic with occasional (sometimes mid-cycle) reset pulses.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 79) == 0) begin
        if ($urandom_range(0, 1) == 1) #2;
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
    end
    idle();
    rst = 1'b0;
    repeat (3) idle();

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
